// File: rtl/iter_muldiv.sv
// Multi-cycle signed/unsigned multiply and restoring divide unit with its own HI/LO registers.
module iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] srcA_i,
    input  logic [WIDTH-1:0] srcB_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             divzero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [ACC_W-1:0]   div_next;
    logic [ACC_W-1:0]   prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand magnitudes: signed ops iterate on |A| and |B|, unsigned ops on the raw values.
    assign op_signed = ~op_i[0];
    assign abs_a = (op_signed && srcA_i[WIDTH-1]) ? (~srcA_i + WIDTH'(1)) : srcA_i;
    assign abs_b = (op_signed && srcB_i[WIDTH-1]) ? (~srcB_i + WIDTH'(1)) : srcB_i;

    // Shift-add multiply step: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: acc = {remainder, dividend/quotient}.
    assign rem_sh   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = {1'b0, rem_sh} - {2'b00, b_q};
    assign div_ok   = ~div_diff[WIDTH+1];
    assign div_next = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ok};

    // Sign correction applied in FIX.
    assign prod_fix = neg_quo_q ? (~acc_q + ACC_W'(1)) : acc_q;
    assign quo_fix  = neg_quo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !cancel_i) begin
                    unique case (op_i)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d  = op_i[1];
                            acc_d     = {{WIDTH{1'b0}}, abs_a};
                            b_d       = abs_b;
                            neg_quo_d = op_signed & (srcA_i[WIDTH-1] ^ srcB_i[WIDTH-1]);
                            neg_rem_d = op_signed & srcA_i[WIDTH-1];
                            dz_d      = op_i[1] && (srcB_i == '0);
                            // Divide by zero skips the iteration: one CALC cycle then FIX.
                            cnt_d     = (op_i[1] && (srcB_i == '0)) ? CNT_W'(WIDTH - 1) : '0;
                            state_d   = S_CALC;
                        end
                        3'd4:    hi_d = srcA_i;
                        3'd5:    lo_d = srcA_i;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!dz_q) begin
                        acc_d = is_div_q ? div_next : mul_next;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel_i) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        divzero_d = 1'b1;
                    end else if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[ACC_W-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign divzero_o = divzero_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed-vector bench for iter_muldiv (WIDTH=32).
module tb_iter_muldiv;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] srcA_i;
    logic [31:0] srcB_i;
    logic        cancel_i;
    logic        busy_o;
    logic        done_o;
    logic        divzero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_chk = 0;
    int n_err = 0;

    iter_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .srcA_i    (srcA_i),
        .srcB_i    (srcB_i),
        .cancel_i  (cancel_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .divzero_o (divzero_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        srcA_i  = a;
        srcB_i  = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        op_i    = 3'd7;
    endtask

    // Edges after the accepting edge until done_o is seen; -1 on timeout.
    task automatic wait_done(input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = i;
                break;
            end
        end
    endtask

    // Count done_o pulses over a window of cycles.
    task automatic count_done(input int cyc, output int n);
        n = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            #1;
            if (done_o) n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic exp_dz,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        issue(op, a, b);
        chk({tag, "_busy"}, 64'(busy_o), 64'(1));
        wait_done(40, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_dz"}, 64'(divzero_o), 64'(exp_dz));
        chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(done_o), 64'(0));
        chk({tag, "_idle"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        start_i  = 1'b0;
        op_i     = 3'd7;
        srcA_i   = '0;
        srcB_i   = '0;
        cancel_i = 1'b0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_dz", 64'(divzero_o), 64'(0));
        chk("rst_hi", 64'(hi_o), 64'(0));
        chk("rst_lo", 64'(lo_o), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Arithmetic vectors
        run_op("mult",  3'd0, 32'hFFFFFFFF, 32'h00000002, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'h00000002, 33, 1'b0, 32'h00000001, 32'hFFFFFFFE);
        run_op("div",   3'd2, 32'hFFFFFFF9, 32'h00000002, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  3'd3, 32'h00000007, 32'h00000002, 33, 1'b0, 32'h00000001, 32'h00000003);
        run_op("divov", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0, 32'h00000000, 32'h80000000);

        // MTHI / MTLO write in place without going busy
        issue(3'd4, 32'h00001234, 32'h0);
        chk("mthi_hi", 64'(hi_o), 64'h1234);
        chk("mthi_busy", 64'(busy_o), 64'(0));
        issue(3'd5, 32'h00005678, 32'h0);
        chk("mtlo_lo", 64'(lo_o), 64'h5678);
        chk("mtlo_done", 64'(done_o), 64'(0));

        // Divide by zero leaves HI/LO untouched
        run_op("divz", 3'd2, 32'h00000009, 32'h00000000, 2, 1'b1, 32'h00001234, 32'h00005678);

        // Flush: second start at cycle 5 ignored, cancel at cycle 10
        issue(3'd0, 32'h00000003, 32'h00000005);
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) begin
                start_i = 1'b1;
                op_i    = 3'd4;
                srcA_i  = 32'hDEADBEEF;
            end
            if (c == 10) cancel_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            op_i    = 3'd7;
        end
        cancel_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'(0));
        count_done(40, n);
        chk("flush_done", 64'(n), 64'(0));
        chk("flush_hi", 64'(hi_o), 64'h1234);
        chk("flush_lo", 64'(lo_o), 64'h5678);

        // Cancel in the FIX cycle beats the commit
        issue(3'd0, 32'h00000003, 32'h00000005);
        for (int c = 0; c < 32; c++) begin
            @(posedge clk);
            #1;
        end
        chk("fixc_busy_pre", 64'(busy_o), 64'(1));
        cancel_i = 1'b1;
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        chk("fixc_busy", 64'(busy_o), 64'(0));
        chk("fixc_done", 64'(done_o), 64'(0));
        count_done(5, n);
        chk("fixc_ndone", 64'(n), 64'(0));
        chk("fixc_hi", 64'(hi_o), 64'h1234);
        chk("fixc_lo", 64'(lo_o), 64'h5678);

        // Start and cancel together in IDLE: cancel wins
        cancel_i = 1'b1;
        issue(3'd4, 32'hCAFEF00D, 32'h0);
        cancel_i = 1'b0;
        chk("idlec_hi", 64'(hi_o), 64'h1234);
        chk("idlec_busy", 64'(busy_o), 64'(0));

        // Unit still works after flushes
        run_op("multu2", 3'd1, 32'h12345678, 32'h00000010, 33, 1'b0, 32'h00000001, 32'h23456780);

        // Asynchronous reset mid-CALC
        issue(3'd3, 32'h00000064, 32'h00000007);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        chk("arst_busy_pre", 64'(busy_o), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_o), 64'(0));
        chk("arst_hi", 64'(hi_o), 64'(0));
        chk("arst_lo", 64'(lo_o), 64'(0));
        chk("arst_done", 64'(done_o), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        count_done(40, n);
        chk("arst_ndone", 64'(n), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
